// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_if
//  Description : Bridge from the core's MEM-stage data port to a Wishbone B4
//                classic master. Each access becomes a multi-cycle bus
//                transaction. The pipeline is held through stallreq_o until
//                the access ends. A pipeline flush aborts the access, and a
//                cycle counter bounds every transaction.
//  Ports       : clk, rst (async, active low)
//                stall_i/flush_i              pipeline control from ctrl
//                cpu_ce/addr/we/sel/data_i    access request from MEM
//                cpu_data_o                   read data to MEM
//                stallreq_o                   combinational stall request
//                bus_err_o                    1-cycle error/timeout pulse
//                wb_ack_i/err_i/data_i        slave response
//                wb_addr/data/we/sel/stb/cyc_o  registered master outputs
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_if #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o
);

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_BUSY = 2'd1;
    localparam logic [1:0]  c_ST_WAIT = 2'd2;
    // Counter value seen in the last BUSY cycle the slave is allowed
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic [31:0] r_rd_buf;
    logic        r_bus_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_sel;
    logic        r_stb;
    logic        r_cyc;

    logic w_start;
    logic w_term_ack;
    logic w_term_err;
    logic w_term;

    assign w_start    = (r_state == c_ST_IDLE) && cpu_ce_i && !flush_i;
    // Ack takes priority when the slave raises ack and err together
    assign w_term_ack = (r_state == c_ST_BUSY) && wb_ack_i;
    assign w_term_err = (r_state == c_ST_BUSY) && !wb_ack_i &&
                        (wb_err_i || (r_cnt == c_TO_LAST));
    assign w_term     = w_term_ack || w_term_err;

    always_comb begin
        w_state_nxt = r_state;
        stallreq_o  = 1'b0;
        cpu_data_o  = 32'd0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    stallreq_o  = 1'b1;
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                stallreq_o = !w_term;
                if (w_term_ack && !flush_i) begin
                    cpu_data_o = wb_data_i;
                end
                if (flush_i) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_term) begin
                    // Another stall source still holds the pipeline: keep
                    // presenting the result until it lets go
                    w_state_nxt = (stall_i != 6'd0) ? c_ST_WAIT : c_ST_IDLE;
                end
            end
            c_ST_WAIT: begin
                cpu_data_o = r_rd_buf;
                if ((stall_i == 6'd0) || flush_i) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 16'd0;
            r_rd_buf  <= 32'd0;
            r_bus_err <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_we      <= 1'b0;
            r_sel     <= 4'd0;
            r_stb     <= 1'b0;
            r_cyc     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bus_err <= w_term_err && !flush_i;
            if (w_start) begin
                r_addr  <= cpu_addr_i;
                r_wdata <= cpu_data_i;
                r_we    <= cpu_we_i;
                r_sel   <= cpu_sel_i;
                r_stb   <= 1'b1;
                r_cyc   <= 1'b1;
                r_cnt   <= 16'd0;
            end
            if (r_state == c_ST_BUSY) begin
                if (r_cnt != c_CNT_MAX) begin
                    r_cnt <= r_cnt + 16'd1;
                end
                if (flush_i || w_term) begin
                    r_cyc <= 1'b0;
                    r_stb <= 1'b0;
                    r_we  <= 1'b0;
                end
                if (w_term && !flush_i) begin
                    r_rd_buf <= w_term_ack ? wb_data_i : 32'd0;
                end
            end
        end
    end

    assign bus_err_o = r_bus_err;
    assign wb_addr_o = r_addr;
    assign wb_data_o = r_wdata;
    assign wb_we_o   = r_we;
    assign wb_sel_o  = r_sel;
    assign wb_stb_o  = r_stb;
    assign wb_cyc_o  = r_cyc;

endmodule
`default_nettype wire
